// File: rtl/mem_noc_arb.sv
// Two-requester round-robin arbiter onto one shared memory port, with an
// in-order route FIFO that steers each response back to its requester.
package mem_noc_arb_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_resp_t;
endpackage

module mem_noc_arb
    import mem_noc_arb_pkg::*;
#(
    parameter int unsigned OUTST_DP = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        m0_req_valid,
    output logic                        m0_req_ready,
    input  mem_req_t                    m0_req,
    output logic                        m0_resp_valid,
    input  logic                        m0_resp_ready,
    output mem_resp_t                   m0_resp,
    input  logic                        m1_req_valid,
    output logic                        m1_req_ready,
    input  mem_req_t                    m1_req,
    output logic                        m1_resp_valid,
    input  logic                        m1_resp_ready,
    output mem_resp_t                   m1_resp,
    output logic                        s_req_valid,
    input  logic                        s_req_ready,
    output mem_req_t                    s_req,
    input  logic                        s_resp_valid,
    output logic                        s_resp_ready,
    input  mem_resp_t                   s_resp,
    output logic [$clog2(OUTST_DP):0]   outst_cnt,
    output logic                        busy
);

    localparam int unsigned     AW      = $clog2(OUTST_DP);
    localparam logic [AW:0]     DEPTH   = OUTST_DP[AW:0];
    localparam logic [AW:0]     CNT_ONE = 1;
    localparam logic [AW-1:0]   PTR_ONE = 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]     r_state;
    logic           r_hold_id;
    logic           r_last;
    logic           r_fifo [OUTST_DP];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_cnt;

    logic w_full;
    logic w_empty;
    logic w_rr_pick;
    logic w_gnt_id;
    logic w_s_req_valid;
    logic w_fire;
    logic w_head_id;
    logic w_resp_route;
    logic w_s_resp_ready;
    logic w_pop;

    assign w_full  = (r_cnt == DEPTH);
    assign w_empty = (r_cnt == '0);

    // On contention the port not granted last wins; a lone requester always wins.
    assign w_rr_pick = (m0_req_valid && m1_req_valid) ? ~r_last : m1_req_valid;
    assign w_gnt_id  = (r_state == ST_HOLD) ? r_hold_id : w_rr_pick;

    assign w_s_req_valid = !rst && ((r_state == ST_HOLD) ||
                                    ((m0_req_valid || m1_req_valid) && !w_full));
    assign w_fire        = w_s_req_valid && s_req_ready;

    assign s_req_valid  = w_s_req_valid;
    assign s_req        = w_gnt_id ? m1_req : m0_req;
    assign m0_req_ready = w_fire && !w_gnt_id;
    assign m1_req_ready = w_fire && w_gnt_id;

    // Responses return in issue order, so the FIFO head names their owner.
    assign w_head_id      = r_fifo[r_rd_ptr];
    assign w_resp_route   = !rst && !w_empty;
    assign w_s_resp_ready = w_resp_route && (w_head_id ? m1_resp_ready : m0_resp_ready);
    assign w_pop          = s_resp_valid && w_s_resp_ready;

    assign s_resp_ready  = w_s_resp_ready;
    assign m0_resp_valid = w_resp_route && !w_head_id && s_resp_valid;
    assign m1_resp_valid = w_resp_route && w_head_id && s_resp_valid;
    assign m0_resp       = s_resp;
    assign m1_resp       = s_resp;

    assign outst_cnt = r_cnt;
    assign busy      = !w_empty || (r_state == ST_HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_hold_id <= 1'b0;
            r_last    <= 1'b1;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_s_req_valid && !s_req_ready) begin
                        r_state   <= ST_HOLD;
                        r_hold_id <= w_gnt_id;
                    end
                end
                default: begin
                    if (s_req_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase

            if (w_fire) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
                r_last   <= w_gnt_id;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end

            case ({w_fire, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_fire) begin
            r_fifo[r_wr_ptr] <= w_gnt_id;
        end
    end

endmodule

// File: tb/tb_mem_noc_arb.sv
// Scoreboard bench for mem_noc_arb: expected grants and response routes are
// queued as stimulus is driven and checked when the handshakes occur.
module tb_mem_noc_arb;
    import mem_noc_arb_pkg::*;

    localparam int unsigned DP = 4;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } resp_exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_ready;
    logic       m1_req_valid, m1_req_ready, m1_resp_valid, m1_resp_ready;
    mem_req_t   m0_req, m1_req, s_req;
    mem_resp_t  m0_resp, m1_resp, s_resp;
    logic       s_req_valid, s_req_ready, s_resp_valid, s_resp_ready;
    logic [$clog2(DP):0] outst_cnt;
    logic       busy;

    int         n_cmp = 0;
    int         n_err = 0;
    int         exp_gnt[$];
    resp_exp_t  exp_resp[$];
    int         mon_id;
    resp_exp_t  mon_r;

    always #5 clk = ~clk;

    mem_noc_arb #(.OUTST_DP(DP)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .m0_req_valid  (m0_req_valid),
        .m0_req_ready  (m0_req_ready),
        .m0_req        (m0_req),
        .m0_resp_valid (m0_resp_valid),
        .m0_resp_ready (m0_resp_ready),
        .m0_resp       (m0_resp),
        .m1_req_valid  (m1_req_valid),
        .m1_req_ready  (m1_req_ready),
        .m1_req        (m1_req),
        .m1_resp_valid (m1_resp_valid),
        .m1_resp_ready (m1_resp_ready),
        .m1_resp       (m1_resp),
        .s_req_valid   (s_req_valid),
        .s_req_ready   (s_req_ready),
        .s_req         (s_req),
        .s_resp_valid  (s_resp_valid),
        .s_resp_ready  (s_resp_ready),
        .s_resp        (s_resp),
        .outst_cnt     (outst_cnt),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req_one(input int port);
        s_req_ready = 1'b1;
        if (port == 1) m1_req_valid = 1'b1;
        else           m0_req_valid = 1'b1;
        exp_gnt.push_back(port);
        step();
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;
    endtask

    task automatic drain_one(input int port, input logic [31:0] data, input int cnt_after);
        s_resp_valid = 1'b1;
        s_resp.rdata = data;
        exp_resp.push_back('{port: port[0], data: data});
        step();
        s_resp_valid = 1'b0;
        #1;
        chk("drain_cnt", outst_cnt, cnt_after);
    endtask

    // Handshake monitor sampled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (s_req_valid && s_req_ready) begin
                chk("gnt_expected", exp_gnt.size() > 0, 1);
                if (exp_gnt.size() > 0) begin
                    mon_id = exp_gnt.pop_front();
                    chk("gnt_ready", {m1_req_ready, m0_req_ready}, (mon_id == 1) ? 2'b10 : 2'b01);
                    chk("gnt_addr", s_req.addr, (mon_id == 1) ? m1_req.addr : m0_req.addr);
                end
            end
            if (s_resp_valid && s_resp_ready) begin
                chk("resp_expected", exp_resp.size() > 0, 1);
                if (exp_resp.size() > 0) begin
                    mon_r = exp_resp.pop_front();
                    chk("resp_route", {m1_resp_valid, m0_resp_valid}, mon_r.port ? 2'b10 : 2'b01);
                    chk("resp_data", mon_r.port ? m1_resp.rdata : m0_resp.rdata, mon_r.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        m0_req = '0; m1_req = '0; s_resp = '0;
        m0_req_valid = 1'b1; m1_req_valid = 1'b1; s_req_ready = 1'b1;
        s_resp_valid = 1'b1; m0_resp_ready = 1'b1; m1_resp_ready = 1'b1;
        step();
        step();
        chk("rst_outputs", {s_req_valid, m1_req_ready, m0_req_ready,
                            s_resp_ready, m1_resp_valid, m0_resp_valid}, '0);
        m0_req_valid = 1'b0; m1_req_valid = 1'b0; s_resp_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("rst_cnt", outst_cnt, 0);
        chk("rst_busy", busy, 0);

        // Continuous contention: alternate grants until the route FIFO fills.
        m0_req.addr = 32'h0000_0A00;
        m1_req.addr = 32'h8000_0B00;
        m0_req_valid = 1'b1; m1_req_valid = 1'b1; s_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_gnt.push_back(i % 2);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("rr_cnt", outst_cnt, i);
        end
        chk("full_s_req_valid", s_req_valid, 0);
        chk("full_req_ready", {m1_req_ready, m0_req_ready}, 2'b00);
        chk("full_busy", busy, 1);
        m0_req_valid = 1'b0; m1_req_valid = 1'b0;
        for (int k = 0; k < 4; k++) drain_one(k % 2, 32'hD000_0000 + k, 3 - k);
        s_resp_valid = 1'b1;
        #1;
        chk("empty_s_resp_ready", s_resp_ready, 0);
        chk("empty_resp_valid", {m1_resp_valid, m0_resp_valid}, 2'b00);
        s_resp_valid = 1'b0;

        // HOLD keeps m0 even though round robin would now favour m1.
        m0_req.addr = 32'h0000_0A10;
        req_one(0);
        m0_req.addr = 32'h0000_0A11;
        m0_req_valid = 1'b1; s_req_ready = 1'b0;
        #1;
        chk("hold_c0_valid", s_req_valid, 1);
        chk("hold_c0_addr", s_req.addr, 32'h0000_0A11);
        step();
        m1_req_valid = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            #1;
            chk("hold_addr", s_req.addr, 32'h0000_0A11);
            chk("hold_valid", s_req_valid, 1);
            chk("hold_ready", {m1_req_ready, m0_req_ready}, 2'b00);
            step();
        end
        s_req_ready = 1'b1;
        exp_gnt.push_back(0);
        step();
        exp_gnt.push_back(1);
        step();
        m0_req_valid = 1'b0; m1_req_valid = 1'b0;
        chk("hold_cnt", outst_cnt, 3);
        drain_one(0, 32'hE000_0001, 2);
        drain_one(0, 32'hE000_0002, 1);
        drain_one(1, 32'hE000_0003, 0);

        // Issue order m1, m0, m1 must be mirrored by response routing.
        req_one(1);
        req_one(0);
        req_one(1);
        chk("order_cnt", outst_cnt, 3);
        drain_one(1, 32'hF000_0001, 2);
        drain_one(0, 32'hF000_0002, 1);
        drain_one(1, 32'hF000_0003, 0);

        // Simultaneous push and pop with a single entry outstanding.
        req_one(0);
        m1_req_valid = 1'b1; s_req_ready = 1'b1;
        exp_gnt.push_back(1);
        s_resp_valid = 1'b1; s_resp.rdata = 32'h1234_0001;
        exp_resp.push_back('{port: 1'b0, data: 32'h1234_0001});
        #1;
        chk("pp_s_resp_ready", s_resp_ready, 1);
        step();
        m1_req_valid = 1'b0; s_resp_valid = 1'b0;
        #1;
        chk("pp_cnt", outst_cnt, 1);
        s_resp_valid = 1'b1; s_resp.rdata = 32'h1234_0002;
        #1;
        chk("pp_head_m1", {m1_resp_valid, m0_resp_valid}, 2'b10);
        exp_resp.push_back('{port: 1'b1, data: 32'h1234_0002});
        step();
        s_resp_valid = 1'b0;
        #1;
        chk("pp_cnt_end", outst_cnt, 0);

        // Response waiting on an empty FIFO is accepted only after a request fires.
        s_resp_valid = 1'b1; s_resp.rdata = 32'h5555_0001;
        #1;
        chk("early_s_resp_ready", s_resp_ready, 0);
        chk("early_resp_valid", {m1_resp_valid, m0_resp_valid}, 2'b00);
        m0_req_valid = 1'b1; s_req_ready = 1'b1;
        exp_gnt.push_back(0);
        #1;
        chk("same_cyc_s_resp_ready", s_resp_ready, 0);
        step();
        m0_req_valid = 1'b0;
        exp_resp.push_back('{port: 1'b0, data: 32'h5555_0001});
        #1;
        chk("late_s_resp_ready", s_resp_ready, 1);
        chk("late_m0_resp_valid", m0_resp_valid, 1);
        step();
        s_resp_valid = 1'b0;
        #1;
        chk("late_cnt", outst_cnt, 0);

        // Reset in HOLD with two outstanding entries discards everything.
        req_one(1);
        req_one(0);
        m1_req_valid = 1'b1; s_req_ready = 1'b0;
        step();
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_cnt", outst_cnt, 2);
        rst = 1'b1;
        #1;
        chk("in_rst_s_req_valid", s_req_valid, 0);
        step();
        rst = 1'b0;
        m1_req_valid = 1'b0;
        #1;
        chk("post_rst_outputs", {s_req_valid, m1_req_ready, m0_req_ready, s_resp_ready,
                                 m1_resp_valid, m0_resp_valid, busy, outst_cnt}, '0);
        m0_req_valid = 1'b1; m1_req_valid = 1'b1;
        #1;
        chk("post_rst_winner", s_req.addr, m0_req.addr);
        s_req_ready = 1'b1;
        exp_gnt.push_back(0);
        step();
        m0_req_valid = 1'b0; m1_req_valid = 1'b0; s_req_ready = 1'b0;
        drain_one(0, 32'h7777_0001, 0);

        for (int i = 0; i < 20 && (exp_gnt.size() > 0 || exp_resp.size() > 0); i++) step();
        chk("sb_gnt_left", exp_gnt.size(), 0);
        chk("sb_resp_left", exp_resp.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
